// File: rtl/dram_loader_pkg.sv
// Shared definitions for the DRAM diagnostic loader: EBUS function codes,
// sequencer states and the A/B/P/J field layout of a dispatch RAM word.
package dram_loader_pkg;

    localparam logic [6:0] DLF_LOAD_ADDR = 7'o060;
    localparam logic [6:0] DLF_LOAD_AB   = 7'o061;
    localparam logic [6:0] DLF_LOAD_J    = 7'o062;
    localparam logic [6:0] DLF_WRITE     = 7'o063;
    localparam logic [6:0] DLF_WRITE_INC = 7'o064;
    localparam logic [6:0] DLF_READ      = 7'o065;
    localparam logic [6:0] DLF_CLEAR     = 7'o067;
    localparam logic [6:0] DLR_STATUS    = 7'o136;
    localparam logic [6:0] DLR_DATA      = 7'o137;

    localparam int EBUS_WIDTH = 36;

    // Word layout {A[0:2], B[0:2], P, J[1:4], J[7:10]}, MSB-first indices
    localparam int DL_A_OFS    = 0;
    localparam int DL_B_OFS    = 3;
    localparam int DL_P_OFS    = 6;
    localparam int DL_J14_OFS  = 7;
    localparam int DL_J710_OFS = 11;

    typedef enum logic [2:0] {
        DL_IDLE,
        DL_WRITE,
        DL_VREAD,
        DL_VCHECK,
        DL_RREAD,
        DL_RCAP
    } dlState_t;

endpackage

// File: rtl/dram_loader.sv
// Diagnostic sequencer that stages, writes and verifies words in the IR
// dispatch RAM from EBUS functions, and reports status back on EBUS.
//
// state     | meaning
// DL_IDLE   | waiting for a diagnostic strobe; LOAD/CLEAR act here
// DL_WRITE  | dramWe high, stage presented on dramDin
// DL_VREAD  | write done, address held for verify read
// DL_VCHECK | compare read data with stage, optional addr increment
// DL_RREAD  | address presented for a plain read
// DL_RCAP   | capture read data into readback
module dram_loader
    import dram_loader_pkg::*;
#(
    parameter int DRAM_SIZE  = 512,
    parameter int DRAM_WIDTH = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          diagStrobe,
    input  logic [0:6]                    diagFunc,
    input  logic                          diagRead,
    input  logic [0:EBUS_WIDTH-1]         ebusIn,
    output logic [0:EBUS_WIDTH-1]         ebusOut,
    output logic                          ebusDriving,
    output logic [0:$clog2(DRAM_SIZE)-1]  dramAddr,
    output logic [0:DRAM_WIDTH-1]         dramDin,
    output logic                          dramWe,
    input  logic [0:DRAM_WIDTH-1]         dramDout,
    output logic                          busy
);

    localparam int ADDR_W = $clog2(DRAM_SIZE);

    dlState_t              state;
    dlState_t              nextState;
    logic [0:ADDR_W-1]     addr;
    logic [0:ADDR_W-1]     addrNext;
    logic [0:DRAM_WIDTH-1] stage;
    logic [0:DRAM_WIDTH-1] readback;
    logic                  verifyErr;
    logic                  overrun;
    logic                  incPending;
    logic                  idle;
    logic                  accept;
    logic [0:EBUS_WIDTH-1] statusWord;
    logic [0:EBUS_WIDTH-1] dataWord;
    logic                  unusedEbus;

    assign idle     = (state == DL_IDLE);
    assign accept   = diagStrobe & idle;
    assign addrNext = (addr == ADDR_W'(DRAM_SIZE - 1)) ? '0 : addr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DL_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            DL_IDLE: begin
                if (accept) begin
                    if (diagFunc == DLF_WRITE || diagFunc == DLF_WRITE_INC) begin
                        nextState = DL_WRITE;
                    end else if (diagFunc == DLF_READ) begin
                        nextState = DL_RREAD;
                    end
                end
            end
            DL_WRITE:  nextState = DL_VREAD;
            DL_VREAD:  nextState = DL_VCHECK;
            DL_VCHECK: nextState = DL_IDLE;
            DL_RREAD:  nextState = DL_RCAP;
            DL_RCAP:   nextState = DL_IDLE;
            default:   nextState = DL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            stage      <= '0;
            readback   <= '0;
            verifyErr  <= 1'b0;
            overrun    <= 1'b0;
            incPending <= 1'b0;
        end else begin
            // Strobes landing on the final busy edge are still rejected
            if (diagStrobe && !idle) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                case (diagFunc)
                    DLF_LOAD_ADDR: addr <= ebusIn[EBUS_WIDTH-ADDR_W:EBUS_WIDTH-1];
                    DLF_LOAD_AB:   stage[0:DL_P_OFS] <= ebusIn[0:DL_P_OFS];
                    DLF_LOAD_J:    stage[DL_J14_OFS:DRAM_WIDTH-1] <= ebusIn[DL_J14_OFS:DRAM_WIDTH-1];
                    DLF_WRITE:     incPending <= 1'b0;
                    DLF_WRITE_INC: incPending <= 1'b1;
                    DLF_CLEAR: begin
                        verifyErr <= 1'b0;
                        overrun   <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state == DL_VCHECK) begin
                readback <= dramDout;
                if (dramDout != stage) begin
                    verifyErr <= 1'b1;
                end
                if (incPending) begin
                    addr <= addrNext;
                end
            end
            if (state == DL_RCAP) begin
                readback <= dramDout;
            end
        end
    end

    assign dramAddr = addr;
    assign dramDin  = stage;
    assign dramWe   = (state == DL_WRITE);
    assign busy     = !idle;

    assign statusWord  = {busy, verifyErr, overrun, ^readback,
                          {(EBUS_WIDTH - 4 - ADDR_W){1'b0}}, addr};
    assign dataWord    = {readback, {(EBUS_WIDTH - DRAM_WIDTH){1'b0}}};
    assign ebusDriving = diagRead & (diagFunc == DLR_STATUS || diagFunc == DLR_DATA);
    assign ebusOut     = !ebusDriving ? {EBUS_WIDTH{1'bz}}
                       : (diagFunc == DLR_STATUS) ? statusWord : dataWord;

    assign unusedEbus = ^ebusIn[DRAM_WIDTH:EBUS_WIDTH-ADDR_W-1];

endmodule

// File: tb/tb_dram_loader.sv
// Directed bench for dram_loader with a behavioural 512x15 RAM that can
// model a stuck-at-0 data bit on its read port.
module tb_dram_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        diagStrobe = 1'b0;
    logic [0:6]  diagFunc = '0;
    logic        diagRead = 1'b0;
    logic [0:35] ebusIn = '0;
    logic [0:35] ebusOut;
    logic        ebusDriving;
    logic [0:8]  dramAddr;
    logic [0:14] dramDin;
    logic        dramWe;
    logic [0:14] dramDout;
    logic        busy;

    logic [0:14] mem [0:511];
    logic [0:14] ramQ = '0;
    logic        stuck = 1'b0;
    localparam logic [0:14] STUCK_MASK = 15'b000100000000000;

    int          checkCount = 0;
    int          passCount = 0;
    int          weCount = 0;
    int          busyCycles = 0;
    logic [8:0]  lastWeAddr = '0;
    logic [14:0] lastWeDin = '0;
    logic [35:0] rd;

    localparam logic [14:0] WORD_A = 15'h56A5;
    localparam logic [14:0] WORD_F = 15'h7FFF;
    localparam logic [14:0] WORD_S = 15'h77FF;

    dram_loader dut (
        .clk(clk),
        .reset(reset),
        .diagStrobe(diagStrobe),
        .diagFunc(diagFunc),
        .diagRead(diagRead),
        .ebusIn(ebusIn),
        .ebusOut(ebusOut),
        .ebusDriving(ebusDriving),
        .dramAddr(dramAddr),
        .dramDin(dramDin),
        .dramWe(dramWe),
        .dramDout(dramDout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dramWe) mem[dramAddr] <= dramDin;
        ramQ <= mem[dramAddr];
    end
    assign dramDout = ramQ & ~(stuck ? STUCK_MASK : 15'b0);

    always @(posedge clk) begin
        if (dramWe) begin
            weCount++;
            lastWeAddr = dramAddr;
            lastWeDin  = dramDin;
        end
        if (busy) busyCycles++;
    end

    function automatic logic [35:0] status(input logic b, input logic v, input logic o,
                                           input logic p, input logic [8:0] a);
        return {b, v, o, p, 23'b0, a};
    endfunction

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [6:0] func, input logic [35:0] data);
        @(negedge clk);
        diagStrobe = 1'b1;
        diagFunc   = func;
        ebusIn     = data;
        @(negedge clk);
        diagStrobe = 1'b0;
        diagFunc   = '0;
        ebusIn     = '0;
    endtask

    task automatic ebusRd(input logic [6:0] func, output logic [35:0] data);
        diagFunc = func;
        diagRead = 1'b1;
        #1;
        data     = ebusOut;
        diagRead = 1'b0;
        diagFunc = '0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {35'b0, busy}, 36'b0);
    endtask

    task automatic clearCounters();
        weCount    = 0;
        busyCycles = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {35'b0, busy}, 36'b0);
        check("rst_we", {35'b0, dramWe}, 36'b0);
        check("rst_drv", {35'b0, ebusDriving}, 36'b0);
        reset = 1'b0;
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("rst_status", rd, 36'b0);

        // Stage 0o254 / AB / J and write with verify
        strobe(7'o060, 36'o254);
        strobe(7'o061, {7'b1010110, 29'b0});
        strobe(7'o062, {7'b0, 8'hA5, 21'b0});
        check("stage_din", {21'b0, dramDin}, {21'b0, WORD_A});
        clearCounters();
        strobe(7'o063, 36'b0);
        check("wr_busy_hi", {35'b0, busy}, 36'b1);
        waitIdle("wr_idle");
        check("wr_we_cnt", weCount, 1);
        check("wr_we_addr", {27'b0, lastWeAddr}, {27'b0, 9'o254});
        check("wr_we_din", {21'b0, lastWeDin}, {21'b0, WORD_A});
        check("wr_busy_cyc", busyCycles, 3);
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("wr_status", rd, status(0, 0, 0, 0, 9'o254));
        diagRead = 1'b1; diagFunc = 7'o137; #1;
        check("rd_driving", {35'b0, ebusDriving}, 36'b1);
        diagRead = 1'b0; diagFunc = '0;
        ebusRd(7'o137, rd);
        check("wr_data", rd, {WORD_A, 21'b0});

        // WRITE_INC wraparound from 511
        strobe(7'o060, 36'o777);
        clearCounters();
        strobe(7'o064, 36'b0);
        waitIdle("inc1_idle");
        check("inc1_addr", {27'b0, lastWeAddr}, {27'b0, 9'd511});
        clearCounters();
        strobe(7'o064, 36'b0);
        waitIdle("inc2_idle");
        check("inc2_addr", {27'b0, lastWeAddr}, {27'b0, 9'd0});
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("inc_final", rd, status(0, 0, 0, 0, 9'd1));
        check("mem511", {21'b0, mem[511]}, {21'b0, WORD_A});

        // Stuck-at-0 on dramDout[3]
        stuck = 1'b1;
        strobe(7'o061, {7'b1111111, 29'b0});
        strobe(7'o062, {7'b0, 8'hFF, 21'b0});
        strobe(7'o063, 36'b0);
        waitIdle("stk_idle");
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("stk_status", rd, status(0, 1, 0, 0, 9'd1));
        ebusRd(7'o137, rd);
        check("stk_data", rd, {WORD_S, 21'b0});
        stuck = 1'b0;
        strobe(7'o063, 36'b0);
        waitIdle("stk2_idle");
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("stk_sticky", rd, status(0, 1, 0, 1, 9'd1));
        strobe(7'o067, 36'b0);
        ebusRd(7'o136, rd);
        check("stk_clear", rd, status(0, 0, 0, 1, 9'd1));

        // Overrun: LOAD_AB arrives the cycle after WRITE
        clearCounters();
        @(negedge clk);
        diagStrobe = 1'b1; diagFunc = 7'o063; ebusIn = '0;
        @(negedge clk);
        diagFunc = 7'o061; ebusIn = '0;
        @(negedge clk);
        diagStrobe = 1'b0; diagFunc = '0;
        waitIdle("ovr_idle");
        check("ovr_we_cnt", weCount, 1);
        check("ovr_we_din", {21'b0, lastWeDin}, {21'b0, WORD_F});
        check("ovr_stage", {21'b0, dramDin}, {21'b0, WORD_F});
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("ovr_bit2", {35'b0, rd[33]}, 36'b1);
        check("ovr_status", rd, status(0, 0, 1, 1, 9'd1));

        // Reset asserted during VREAD
        strobe(7'o060, 36'd5);
        strobe(7'o063, 36'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we", {35'b0, dramWe}, 36'b0);
        check("mid_rst_busy", {35'b0, busy}, 36'b0);
        @(negedge clk);
        ebusRd(7'o136, rd);
        check("mid_rst_status", rd, 36'b0);
        ebusRd(7'o137, rd);
        check("mid_rst_data", rd, 36'b0);
        check("mid_rst_stage", {21'b0, dramDin}, 36'b0);
        reset = 1'b0;
        clearCounters();
        strobe(7'o065, 36'b0);
        waitIdle("rd_idle");
        check("rd_busy_cyc", busyCycles, 2);
        check("rd_no_we", weCount, 0);
        @(negedge clk);
        ebusRd(7'o137, rd);
        check("rd_data", rd, {WORD_A, 21'b0});
        ebusRd(7'o136, rd);
        check("rd_status", rd, status(0, 0, 0, 0, 9'd0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
